popcount_pattern_gen: RTL and testbench
=======================================

// Module: popcount_pattern_gen
// PURPOSE
//  Inverse of the team's ones-counter: given a target ones-count k, streams every WIDTH-bit word
//  whose popcount equals k, in ascending numeric order, one word per accepted transfer.
//  Produces stimulus and test-pattern streams for popcount and balance-checking datapaths.
//  Uses a valid/ready output stream and a start/busy command interface.
// PARAMETERS
//  WIDTH  8                     word width in bits (WIDTH >= 2)
//  CNT_W  $clog2(WIDTH+1)       width of k; default 4 for WIDTH=8
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      command strobe; sampled only in IDLE
//  k          in   CNT_W  target ones-count; sampled with start
//  busy       out  1      1 while in EMIT
//  err        out  1      one-cycle pulse when start is given with k > WIDTH
//  out_valid  out  1      out_data is valid
//  out_ready  in   1      downstream accepts the word
//  out_data   out  WIDTH  current pattern (popcount == k)
//  out_last   out  1      marks the final pattern of the sequence; qualified by out_valid
// BEHAVIOUR
//  - Reset value of every output is 0: busy, err, out_valid, out_data, out_last. The FSM state is IDLE.
//  - FSM states: IDLE, EMIT.
//  - IDLE, start=1, k<=WIDTH:
//    - load pattern = (1<<k)-1 and latch k.
//    - Go to EMIT. out_valid=1 and busy=1 from the next cycle (1-cycle latency).
//  - IDLE, start=1, k>WIDTH:
//    - err=1 for exactly one cycle. Stay in IDLE. out_valid stays 0.
//  - EMIT, transfer (out_valid & out_ready):
//    - If out_last, go to IDLE. out_valid, busy and out_last are 0 the next cycle.
//    - Otherwise pattern <= successor(pattern), and out_valid stays 1.
//    - Throughput is 1 word/cycle while out_ready is held high.
//  - successor: next larger word with the same popcount (Gosper), computed without a divider:
//    - c = x & -x; r = x + c (WIDTH+1 bits)
//    - next = r[WIDTH-1:0] | (((r ^ x) >> 2) >> ctz(c))
//    - ctz comes from a priority encoder.
//  - out_last = (pattern == ((1<<k)-1) << (WIDTH-k)), i.e. the k ones packed at the MSB end.
//    - k=0 and k=WIDTH each emit a single word with out_last=1.
//  - Sequence length = C(WIDTH,k). The pattern never wraps; the successor is never applied after last.
//  - Backpressure: while out_valid & !out_ready, out_data and out_last hold stable. out_valid never drops before the transfer.
//  - start while busy: ignored. No err, no effect on the stream.
//  - start in the same cycle as the final transfer: ignored. The block is in EMIT, so issue the next start once busy is 0.
//  - Reset mid-stream: aborts immediately and asynchronously; all outputs go to 0 and the FSM to IDLE. No partial-sequence memory.
//  - err is registered. It never coincides with out_valid=1.
// TESTING
//  1. k=0, start, out_ready=1 -> one word 0x00 with out_last=1; busy falls the cycle after.
//  2. k=1, out_ready=1 -> 0x01,0x02,0x04,...,0x80 on consecutive cycles (8 words); out_last only on 0x80.
//  3. k=2 -> 28 words 0x03,0x05,0x06,0x09,0x0A,0x0C,0x11,...,0xC0; scoreboard checks strictly ascending order, popcount==2, and the count.
//  4. k=8 -> single 0xFF with out_last=1. k=9 -> err pulse of 1 cycle, out_valid stays 0, busy stays 0.
//  5. k=4 with pseudo-random out_ready -> data held during stalls; 70 words total, ending at 0xF0; a start pulse mid-stream is ignored.
//  6. k=3 with reset asserted after the 5th transfer -> outputs 0 at once; a later start with k=3 restarts at 0x07.

Source files
------------

// File: rtl/popcount_pattern_gen.sv
// popcount_pattern_gen
// For a requested ones-count k, this block streams every WIDTH-bit word
// whose popcount is k. Words come out in ascending numeric order, one word
// per accepted valid/ready transfer. A command is a start strobe with k.
// The block reports busy while it is streaming and raises a one-cycle err
// pulse when k is out of range.
module popcount_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] k,
    output logic             busy,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   pattern;
    logic [CNT_W-1:0]   k_reg;

    logic               k_over;
    logic               accept_cmd;
    logic               reject_cmd;
    logic               transfer;

    logic [WIDTH-1:0]   first_pattern;
    logic [WIDTH-1:0]   last_ones;
    logic [WIDTH-1:0]   last_pattern;

    logic [WIDTH-1:0]   low_bit;
    logic [WIDTH:0]     ripple;
    logic [WIDTH:0]     changed;
    logic [WIDTH-1:0]   changed_down;
    logic [CNT_W-1:0]   low_pos;
    logic [WIDTH-1:0]   next_pattern;

    // Decode the command qualifiers. Commands are only honoured in IDLE.
    always_comb begin
        k_over     = (k > CNT_W'(WIDTH));
        accept_cmd = (state == IDLE) && start && !k_over;
        reject_cmd = (state == IDLE) && start && k_over;
        transfer   = out_valid && out_ready;
    end

    // Derive the first and final words of a sequence: k ones at the LSB end
    // and k ones at the MSB end. A shift by the full width clears the mask,
    // so both k=0 and k=WIDTH fall out without special cases.
    always_comb begin
        first_pattern = ~({WIDTH{1'b1}} << k);
        last_ones     = ~({WIDTH{1'b1}} << k_reg);
        last_pattern  = last_ones << (CNT_W'(WIDTH) - k_reg);
    end

    // Find the lowest set bit position of the current word. The loop runs
    // from the top down so that the lowest set bit is the last one to
    // write low_pos.
    always_comb begin
        low_bit = pattern & (~pattern + WIDTH'(1));
        low_pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (low_bit[i]) begin
                low_pos = CNT_W'(i);
            end
        end
    end

    // Compute the next larger word with the same popcount (Gosper's step).
    // Adding the lowest set bit ripples the lowest block of ones up by one
    // position. The bits that changed, shifted back down to the LSB end,
    // refill the ones that were consumed. Shifting by the bit position
    // replaces the usual division by the lowest set bit.
    always_comb begin
        ripple       = {1'b0, pattern} + {1'b0, low_bit};
        changed      = ripple ^ {1'b0, pattern};
        changed_down = WIDTH'(changed >> 2);
        next_pattern = ripple[WIDTH-1:0] | (changed_down >> low_pos);
    end

    // Hold the FSM state. Reset aborts any stream in progress at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Choose the next state. Leave IDLE on a legal start. Return to IDLE
    // once the final word has been accepted downstream.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_cmd) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (transfer && out_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Update the pattern register, the latched k and the registered error
    // pulse. The successor is only taken for a word that is not the last
    // one, so the sequence never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= '0;
            k_reg   <= '0;
            err     <= 1'b0;
        end else begin
            err <= reject_cmd;
            if (accept_cmd) begin
                pattern <= first_pattern;
                k_reg   <= k;
            end else if ((state == EMIT) && transfer && !out_last) begin
                pattern <= next_pattern;
            end
        end
    end

    // Drive the stream and status outputs from the state. Data and last are
    // forced to zero outside EMIT so that the idle bus is quiet.
    always_comb begin
        busy      = (state == EMIT);
        out_valid = (state == EMIT);
        out_data  = (state == EMIT) ? pattern : '0;
        out_last  = (state == EMIT) && (pattern == last_pattern);
    end

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Testbench for popcount_pattern_gen. The expected streams are built by
// filtering all 8-bit values by popcount, in ascending order.
module tb_popcount_pattern_gen;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] k;
    logic             busy;
    logic             err;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    int checks;
    int errors;

    popcount_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k         (k),
        .busy      (busy),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Free-running clock with a 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and count the result.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check that every output is in its idle state.
    task automatic check_idle(input string tag);
        check_output({tag, " busy"}, 32'(busy), 32'd0);
        check_output({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check_output({tag, " out_data"}, 32'(out_data), 32'd0);
        check_output({tag, " out_last"}, 32'(out_last), 32'd0);
    endtask

    // Pulse start for one cycle with the given k. Return at the falling
    // edge after the sampling edge.
    task automatic apply_stimulus(input int kv);
        @(negedge clk);
        start = 1'b1;
        k     = CNT_W'(kv);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Run one full sequence for kv and check it against the reference list.
    // rand_ready stalls the stream at random. poke_start issues ignored
    // start pulses mid-stream and during the final transfer. If abort_after
    // is nonzero, reset is asserted right after that many transfers.
    task automatic run_stream(input int kv, input bit rand_ready, input bit poke_start,
                              input int abort_after);
        int               expq[$];
        int               idx;
        int               cycles;
        bit               stalled;
        logic [WIDTH-1:0] held;
        bit               aborted;
        for (int v = 0; v < (1 << WIDTH); v++) begin
            if ($countones(v) == kv) expq.push_back(v);
        end
        apply_stimulus(kv);
        check_output($sformatf("k%0d busy after start", kv), 32'(busy), 32'd1);
        check_output($sformatf("k%0d valid after start", kv), 32'(out_valid), 32'd1);
        idx     = 0;
        cycles  = 0;
        stalled = 1'b0;
        held    = '0;
        aborted = 1'b0;
        while (idx < expq.size() && cycles < 2000 && !aborted) begin
            check_output($sformatf("k%0d valid w%0d", kv, idx), 32'(out_valid), 32'd1);
            check_output($sformatf("k%0d err w%0d", kv, idx), 32'(err), 32'd0);
            if (stalled) check_output($sformatf("k%0d hold w%0d", kv, idx), 32'(out_data), 32'(held));
            check_output($sformatf("k%0d data w%0d", kv, idx), 32'(out_data), 32'(expq[idx]));
            check_output($sformatf("k%0d popcount w%0d", kv, idx), 32'($countones(out_data)), 32'(kv));
            check_output($sformatf("k%0d last w%0d", kv, idx), 32'(out_last),
                         32'(idx == expq.size() - 1));
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke_start && (idx == expq.size() / 2 || idx == expq.size() - 1)) begin
                start = 1'b1;
                k     = CNT_W'((idx == expq.size() - 1) ? 1 : 2);
            end else begin
                start = 1'b0;
            end
            stalled = !out_ready;
            held    = out_data;
            if (out_ready) begin
                idx++;
                if (abort_after != 0 && idx == abort_after) begin
                    @(posedge clk);
                    #2;
                    reset = 1'b1;
                    #1;
                    check_idle($sformatf("k%0d abort", kv));
                    check_output($sformatf("k%0d abort err", kv), 32'(err), 32'd0);
                    @(negedge clk);
                    reset = 1'b0;
                    aborted = 1'b1;
                end
            end
            if (!aborted) begin
                @(negedge clk);
                cycles++;
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (!aborted) begin
            check_output($sformatf("k%0d words", kv), 32'(idx), 32'(expq.size()));
            if (!rand_ready) check_output($sformatf("k%0d cycles", kv), 32'(cycles), 32'(expq.size()));
            check_idle($sformatf("k%0d done", kv));
            @(negedge clk);
            check_idle($sformatf("k%0d still idle", kv));
            check_output($sformatf("k%0d err after", kv), 32'(err), 32'd0);
        end
    endtask

    // Directed sequence of scenarios.
    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        k         = '0;
        out_ready = 1'b0;
        #3;
        check_idle("reset");
        check_output("reset err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post reset");

        run_stream(0, 1'b0, 1'b0, 0);
        run_stream(1, 1'b0, 1'b0, 0);
        run_stream(2, 1'b0, 1'b0, 0);
        run_stream(8, 1'b0, 1'b0, 0);

        apply_stimulus(9);
        check_output("k9 err pulse", 32'(err), 32'd1);
        check_output("k9 valid", 32'(out_valid), 32'd0);
        check_output("k9 busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_output("k9 err cleared", 32'(err), 32'd0);
        check_output("k9 valid later", 32'(out_valid), 32'd0);

        run_stream(4, 1'b1, 1'b1, 0);
        run_stream(3, 1'b1, 1'b0, 5);
        run_stream(3, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
